// File: rtl/sdram_scan_tester.sv
`default_nettype none
// ============================================================================
// Module  : sdram_scan_tester
// Brief   : Writes a byte pattern over 0..SCAN_LAST, reads it back, and flags
//           any mismatch or controller timeout. Optional SDRAM_TEST_LOOP_EN
//           repeats passes with the pattern inverted on alternate passes.
// Rev     : 1.0 - initial release
// ============================================================================
module sdram_scan_tester #(
    parameter int          ADDR_W      = 27,
    parameter int          DATA_W      = 8,
    parameter int unsigned SCAN_LAST   = 32'h07FF_FFFF,
    parameter int          START_DELAY = 20000,
    parameter int          TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_busy,
    input  logic              sdram_data_ready,
    input  logic [DATA_W-1:0] sdram_dout,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [DATA_W-1:0] sdram_din,
    output logic              data_correct,
    output logic              scan_finished,
    output logic              led_succeed,
    output logic              led_fault
);

    localparam int c_INIT_W = $clog2(START_DELAY + 2);
    localparam int c_WAIT_W = $clog2(TIMEOUT + 2);

    localparam logic [ADDR_W-1:0]   c_SCAN_LAST = ADDR_W'(SCAN_LAST);
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT   = c_WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_WR_ISSUE  = 3'd1,
        S_WR_WAIT   = 3'd2,
        S_RD_ISSUE  = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_DONE      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_INIT_W-1:0] r_init_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_read;
    logic                r_write;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_din;
    logic                r_data_correct;
    logic                r_scan_finished;
    logic                r_timeout;
    logic                r_led_succeed;
    logic                r_led_fault;

    logic [7:0]          w_pass_inv;
    logic [15:0]         w_addr16;
    logic [DATA_W-1:0]   w_pat;
    logic [c_WAIT_W-1:0] w_wait_next;
    logic                w_at_last;
    logic                w_wait_expired;

`ifdef SDRAM_TEST_LOOP_EN
    logic [7:0]          r_pass_inv;
    assign w_pass_inv = r_pass_inv;
`else
    assign w_pass_inv = 8'h00;
`endif

    // Pattern folds the two low address bytes so neighbouring rows differ.
    assign w_addr16       = 16'(r_addr);
    assign w_pat          = DATA_W'(w_addr16[7:0] ^ w_addr16[15:8] ^ w_pass_inv);
    assign w_wait_next    = r_wait_cnt + 1'b1;
    assign w_at_last      = (r_addr == c_SCAN_LAST);
    assign w_wait_expired = (w_wait_next == c_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_WAIT_INIT;
            r_addr          <= '0;
            r_init_cnt      <= '0;
            r_wait_cnt      <= '0;
            r_read          <= 1'b0;
            r_write         <= 1'b0;
            r_address       <= '0;
            r_din           <= '0;
            r_data_correct  <= 1'b1;
            r_scan_finished <= 1'b0;
            r_timeout       <= 1'b0;
            r_led_succeed   <= 1'b0;
            r_led_fault     <= 1'b0;
`ifdef SDRAM_TEST_LOOP_EN
            r_pass_inv      <= 8'h00;
`endif
        end else begin
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_led_succeed <= r_scan_finished & r_data_correct & ~r_timeout;
            r_led_fault   <= ~r_data_correct | r_timeout;

            case (r_state)
                S_WAIT_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_state    <= S_WR_ISSUE;
                        r_addr     <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end

                S_WR_ISSUE: begin
                    if (!sdram_busy) begin
                        r_write    <= 1'b1;
                        r_address  <= r_addr;
                        r_din      <= w_pat;
                        r_state    <= S_WR_WAIT;
                        r_wait_cnt <= '0;
                    end
                end

                // Busy is only meaningful from the second cycle after the pulse.
                S_WR_WAIT: begin
                    if ((r_wait_cnt != '0) && !sdram_busy) begin
                        r_wait_cnt <= '0;
                        if (w_at_last) begin
                            r_addr  <= '0;
                            r_state <= S_RD_ISSUE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_WR_ISSUE;
                        end
                    end else if (w_wait_expired) begin
                        r_wait_cnt      <= '0;
                        r_timeout       <= 1'b1;
                        r_scan_finished <= 1'b0;
                        r_state         <= S_FAULT;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                    end
                end

                S_RD_ISSUE: begin
                    if (!sdram_busy) begin
                        r_read     <= 1'b1;
                        r_address  <= r_addr;
                        r_state    <= S_RD_WAIT;
                        r_wait_cnt <= '0;
                    end
                end

                S_RD_WAIT: begin
                    if (sdram_data_ready) begin
                        r_wait_cnt <= '0;
                        if (sdram_dout != w_pat) begin
                            r_data_correct <= 1'b0;
                        end
                        if (w_at_last) begin
                            r_scan_finished <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_RD_ISSUE;
                        end
                    end else if (w_wait_expired) begin
                        r_wait_cnt      <= '0;
                        r_timeout       <= 1'b1;
                        r_scan_finished <= 1'b0;
                        r_state         <= S_FAULT;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                    end
                end

                S_DONE: begin
`ifdef SDRAM_TEST_LOOP_EN
                    r_addr     <= '0;
                    r_wait_cnt <= '0;
                    r_pass_inv <= ~r_pass_inv;
                    r_state    <= S_WR_ISSUE;
`else
                    r_state    <= S_DONE;
`endif
                end

                S_FAULT: begin
                    r_state <= S_FAULT;
                end

                default: begin
                    r_state <= S_WAIT_INIT;
                end
            endcase
        end
    end

    assign sdram_read    = r_read;
    assign sdram_write   = r_write;
    assign sdram_address = r_address;
    assign sdram_din     = r_din;
    assign data_correct  = r_data_correct;
    assign scan_finished = r_scan_finished;
    assign led_succeed   = r_led_succeed;
    assign led_fault     = r_led_fault;

endmodule
`default_nettype wire

// File: tb/tb_sdram_scan_tester.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_scan_tester
// Brief   : Directed bench for sdram_scan_tester with a small controller model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_sdram_scan_tester;

    localparam int c_ADDR_W = 27;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                m_busy = 1'b0;
    logic                force_busy = 1'b0;
    logic                data_ready = 1'b0;
    logic [7:0]          dout = 8'h00;
    logic                sdram_read;
    logic                sdram_write;
    logic [c_ADDR_W-1:0] sdram_address;
    logic [7:0]          sdram_din;
    logic                data_correct;
    logic                scan_finished;
    logic                led_succeed;
    logic                led_fault;
    wire                 w_busy = m_busy | force_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // controller model state
    logic [7:0]          mem [16];
    logic [c_ADDR_W-1:0] wr_addr_log [64];
    logic [7:0]          wr_din_log  [64];
    int   wr_count = 0;
    int   rd_count = 0;
    int   bcnt = 0;
    int   rcnt = 0;
    logic rd_pend = 1'b0;
    logic [7:0] rdata = 8'h00;
    int   corrupt_addr = -1;
    int   drop_addr = -1;
    int   both_cnt = 0;
    int   over_cnt = 0;
    int   saved_wr;
    int   saved_rd;

    sdram_scan_tester #(
        .ADDR_W      (c_ADDR_W),
        .DATA_W      (8),
        .SCAN_LAST   (15),
        .START_DELAY (4),
        .TIMEOUT     (31)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sdram_busy       (w_busy),
        .sdram_data_ready (data_ready),
        .sdram_dout       (dout),
        .sdram_read       (sdram_read),
        .sdram_write      (sdram_write),
        .sdram_address    (sdram_address),
        .sdram_din        (sdram_din),
        .data_correct     (data_correct),
        .scan_finished    (scan_finished),
        .led_succeed      (led_succeed),
        .led_fault        (led_fault)
    );

    always #5 clk = ~clk;

    // Busy for 3 cycles after each command; read data 2 cycles after busy clears.
    always @(negedge clk) begin
        if (sdram_read && sdram_write) both_cnt++;
        if (sdram_address > 27'd15) over_cnt++;
        if (!rst_n) begin
            m_busy = 1'b0; data_ready = 1'b0; bcnt = 0; rcnt = 0;
            rd_pend = 1'b0; wr_count = 0; rd_count = 0;
        end else begin
            data_ready = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    data_ready = 1'b1;
                    dout = rdata;
                end
            end
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0 && rd_pend) begin
                    rcnt = 2;
                    rd_pend = 1'b0;
                end
            end
            if (sdram_write) begin
                mem[sdram_address[3:0]] = sdram_din;
                if (wr_count < 64) begin
                    wr_addr_log[wr_count] = sdram_address;
                    wr_din_log[wr_count]  = sdram_din;
                end
                wr_count++;
                bcnt = 3;
            end
            if (sdram_read) begin
                rd_count++;
                bcnt = 3;
                if (int'(sdram_address) != drop_addr) begin
                    rd_pend = 1'b1;
                    rdata = (int'(sdram_address) == corrupt_addr) ? 8'hA5 : mem[sdram_address[3:0]];
                end
            end
            m_busy = (bcnt > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int sel, input int n, input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            case (sel)
                0:       ok = (rd_count >= n);
                1:       ok = (wr_count >= n);
                2:       ok = (scan_finished === 1'b1);
                default: ok = (led_fault === 1'b1);
            endcase
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"},  {31'd0, sdram_read}, 32'd0);
        check({tag, "_write"}, {31'd0, sdram_write}, 32'd0);
        check({tag, "_addr"},  32'(sdram_address), 32'd0);
        check({tag, "_din"},   32'(sdram_din), 32'd0);
        check({tag, "_dc"},    {31'd0, data_correct}, 32'd1);
        check({tag, "_sf"},    {31'd0, scan_finished}, 32'd0);
        check({tag, "_ls"},    {31'd0, led_succeed}, 32'd0);
        check({tag, "_lf"},    {31'd0, led_fault}, 32'd0);
    endtask

    initial begin
        // reset values
        repeat (2) step();
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // full clean pass
        wait_for(2, 1, 1000, "pass_finish");
        check("pass_wr_count", 32'(wr_count), 32'd16);
        check("pass_rd_count", 32'(rd_count), 32'd16);
        check("pass_dc", {31'd0, data_correct}, 32'd1);
        check("pass_log0_din", 32'(wr_din_log[0]), 32'h00);
        check("pass_log5_addr", 32'(wr_addr_log[5]), 32'd5);
        check("pass_log5_din", 32'(wr_din_log[5]), 32'h05);
        check("pass_log12_din", 32'(wr_din_log[12]), 32'h0C);
        repeat (2) step();
        check("pass_led_succeed", {31'd0, led_succeed}, 32'd1);
        check("pass_led_fault", {31'd0, led_fault}, 32'd0);
`ifdef SDRAM_TEST_LOOP_EN
        wait_for(1, 19, 500, "loop_wr2_wait");
        check("loop_log16_din", 32'(wr_din_log[16]), 32'hFF);
        check("loop_log18_addr", 32'(wr_addr_log[18]), 32'd2);
        check("loop_log18_din", 32'(wr_din_log[18]), 32'hFD);
        check("loop_sf_held", {31'd0, scan_finished}, 32'd1);
        wait_for(0, 32, 1000, "loop_rd_wait");
        repeat (8) step();
        check("loop_dc", {31'd0, data_correct}, 32'd1);
        check("loop_sf_end", {31'd0, scan_finished}, 32'd1);
`else
        repeat (20) step();
        check("done_no_more_wr", 32'(wr_count), 32'd16);
        check("done_sf_held", {31'd0, scan_finished}, 32'd1);
`endif

        // busy held at the first write issue
        force_busy = 1'b1;
        do_reset();
        repeat (54) step();
        check("busy_no_wr_count", 32'(wr_count), 32'd0);
        check("busy_no_wr_pulse", {31'd0, sdram_write}, 32'd0);
        force_busy = 1'b0;
        step();
        check("busy_release_pulse", {31'd0, sdram_write}, 32'd1);
        check("busy_release_addr", 32'(sdram_address), 32'd0);
        step();
        check("busy_pulse_single", {31'd0, sdram_write}, 32'd0);
        wait_for(2, 1, 1000, "busy_finish");
        check("busy_wr_total", 32'(wr_count), 32'd16);

        // corrupted read at address 7
        corrupt_addr = 7;
        do_reset();
        wait_for(0, 8, 1000, "bad_rd7_issue");
        check("bad_dc_before", {31'd0, data_correct}, 32'd1);
        wait_for(0, 9, 100, "bad_rd8_issue");
        check("bad_dc_after", {31'd0, data_correct}, 32'd0);
        wait_for(2, 1, 1000, "bad_finish");
        check("bad_rd_count", 32'(rd_count), 32'd16);
        repeat (2) step();
        check("bad_led_fault", {31'd0, led_fault}, 32'd1);
        check("bad_led_succeed", {31'd0, led_succeed}, 32'd0);
        corrupt_addr = -1;

        // reset asserted during the read wait at address 9
        do_reset();
        wait_for(0, 10, 1000, "mid_rd9_issue");
        check("mid_addr_before", 32'(sdram_address), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("mid_init_no_wr", {31'd0, sdram_write}, 32'd0);
        step();
        check("mid_first_wr", {31'd0, sdram_write}, 32'd1);
        check("mid_first_addr", 32'(sdram_address), 32'd0);
        check("mid_first_din", 32'(sdram_din), 32'h00);

        // data_ready never returns for the read of address 3
        drop_addr = 3;
        do_reset();
        wait_for(0, 4, 1000, "to_rd3_issue");
        repeat (20) step();
        check("to_not_yet", {31'd0, led_fault}, 32'd0);
        wait_for(3, 1, 20, "to_fault");
        check("to_sf", {31'd0, scan_finished}, 32'd0);
        check("to_succeed", {31'd0, led_succeed}, 32'd0);
        saved_wr = wr_count;
        saved_rd = rd_count;
        repeat (30) step();
        check("to_no_more_rd", 32'(rd_count), 32'(saved_rd));
        check("to_no_more_wr", 32'(wr_count), 32'(saved_wr));
        check("to_lf_held", {31'd0, led_fault}, 32'd1);
        drop_addr = -1;

        check("never_both_cmds", 32'(both_cnt), 32'd0);
        check("addr_in_range", 32'(over_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
